// File: rtl/fdu_heartbeat_gen_if.sv
// fdu_heartbeat_gen_if: heartbeat control/status bundle (master drives enable/kick/inject, slave drives fdu/wrap/stalled)
interface fdu_heartbeat_gen_if;
  logic       enable;
  logic       kick;
  logic       inject;
  logic [2:0] fdu;
  logic       wrap;
  logic       stalled;
  modport master (output enable, kick, inject, input fdu, wrap, stalled);
  modport slave (input enable, kick, inject, output fdu, wrap, stalled);
endinterface

// File: rtl/fdu_heartbeat_gen.sv
// fdu_heartbeat_gen: 3-bit Gray heartbeat transmitter with kick-timeout stall and fault injection
//   clk        in  clock
//   reset      in  asynchronous active-high reset
//   hb.enable  in  level, 1 = generate heartbeat
//   hb.kick    in  single-cycle firmware-alive pulse
//   hb.inject  in  single-cycle request for one illegal code
//   hb.fdu     out registered Gray code to the monitor
//   hb.wrap    out one-cycle pulse on the 100->000 transition
//   hb.stalled out level, 1 while frozen on kick timeout
module fdu_heartbeat_gen #(
  parameter int STEP_CYCLES  = 100000,
  parameter int KICK_TIMEOUT = 2000000,
  parameter int CNT_W        = 24
) (
  input logic                clk,
  input logic                reset,
  fdu_heartbeat_gen_if.slave hb
);
  typedef enum logic [1:0] {OFF, RUN, STALL} state_t;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] KICK_LAST = CNT_W'(KICK_TIMEOUT - 1);
  state_t           r_state, w_state_nx;
  logic [2:0]       r_idx, w_idx_nx, r_fdu, w_fdu_nx;
  logic             r_wrap, w_wrap_nx, r_stalled, w_stalled_nx;
  logic             r_pend, w_pend_nx, r_bad, w_bad_nx;
  logic [CNT_W-1:0] r_step_cnt, w_step_nx, r_kick_cnt, w_kick_nx;
  logic             w_step, w_tmo;
  logic [2:0]       w_idx_inc;
  assign w_step    = r_step_cnt == STEP_LAST;
  assign w_tmo     = r_kick_cnt == KICK_LAST;
  assign w_idx_inc = r_idx + 3'd1;
  always_comb begin
    w_state_nx   = r_state;
    w_idx_nx     = r_idx;
    w_fdu_nx     = r_fdu;
    w_wrap_nx    = 1'b0;
    w_stalled_nx = r_stalled;
    w_step_nx    = r_step_cnt;
    w_kick_nx    = r_kick_cnt;
    w_pend_nx    = r_pend;
    w_bad_nx     = r_bad;
    // disable and the stall-recovery kick both restart from a clean zero state
    if (!hb.enable || (r_state == STALL && hb.kick)) begin
      w_state_nx   = hb.enable ? RUN : OFF;
      w_idx_nx     = 3'd0;
      w_fdu_nx     = 3'd0;
      w_stalled_nx = 1'b0;
      w_step_nx    = '0;
      w_kick_nx    = '0;
      w_pend_nx    = 1'b0;
      w_bad_nx     = 1'b0;
    end else if (r_state == OFF) begin
      w_state_nx = RUN;
    end else if (r_state == RUN) begin
      w_step_nx = w_step ? '0 : r_step_cnt + 1'b1;
      w_kick_nx = hb.kick ? '0 : r_kick_cnt + 1'b1;
      w_pend_nx = r_pend | hb.inject;
      if (!hb.kick && w_tmo) begin
        w_state_nx   = STALL;
        w_stalled_nx = 1'b1;
        w_kick_nx    = r_kick_cnt;
      end
      // r_bad marks that the illegal code is already on the wire
      if (w_step) begin
        if (r_bad) begin
          w_idx_nx  = 3'd0;
          w_fdu_nx  = 3'd0;
          w_pend_nx = 1'b0;
          w_bad_nx  = 1'b0;
        end else if (r_pend) begin
          w_fdu_nx = ~r_fdu;
          w_bad_nx = 1'b1;
        end else begin
          w_idx_nx  = w_idx_inc;
          w_fdu_nx  = w_idx_inc ^ (w_idx_inc >> 1);
          w_wrap_nx = r_idx == 3'd7;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= OFF;
      r_idx      <= 3'd0;
      r_fdu      <= 3'd0;
      r_wrap     <= 1'b0;
      r_stalled  <= 1'b0;
      r_step_cnt <= '0;
      r_kick_cnt <= '0;
      r_pend     <= 1'b0;
      r_bad      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_idx      <= w_idx_nx;
      r_fdu      <= w_fdu_nx;
      r_wrap     <= w_wrap_nx;
      r_stalled  <= w_stalled_nx;
      r_step_cnt <= w_step_nx;
      r_kick_cnt <= w_kick_nx;
      r_pend     <= w_pend_nx;
      r_bad      <= w_bad_nx;
    end
  end
  assign hb.fdu     = r_fdu;
  assign hb.wrap    = r_wrap;
  assign hb.stalled = r_stalled;
endmodule

// File: tb/tb_fdu_heartbeat_gen.sv
// tb_fdu_heartbeat_gen: directed and random stimulus checked against a position-based heartbeat model
module tb_fdu_heartbeat_gen;
  localparam int STEP = 4;
  localparam int KT = 64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  fdu_heartbeat_gen_if hb();
  fdu_heartbeat_gen #(.STEP_CYCLES(STEP), .KICK_TIMEOUT(KT), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .hb(hb)
  );
  always #5 clk = ~clk;
  logic [2:0] gt [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
  // model: mode 0=off 1=run 2=stall; pos = clocks since sequence origin; inj_at = step index of the illegal code
  int mode, pos, since, inj_at;
  logic [2:0] m_fdu;
  logic m_wrap, m_stalled;
  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic mreset();
    mode = 0; pos = 0; since = 0; inj_at = -1;
    m_fdu = 3'b000; m_wrap = 1'b0; m_stalled = 1'b0;
  endtask
  task automatic mstep(input bit en, input bit k, input bit inj);
    m_wrap = 1'b0;
    if (!en) mreset();
    else if (mode == 0) begin
      mode = 1; pos = 0; since = 0;
    end else if (mode == 2) begin
      if (k) begin
        mreset();
        mode = 1;
      end
    end else begin
      if (inj && inj_at < 0) inj_at = (pos + 1) / STEP + 1;
      if (!k && since == KT - 1) begin
        mode = 2;
        m_stalled = 1'b1;
      end
      since = k ? 0 : since + 1;
      pos++;
      if (inj_at >= 0 && pos == (inj_at + 1) * STEP) begin
        pos = 0; inj_at = -1; m_fdu = 3'b000;
      end else if (inj_at >= 0 && pos / STEP == inj_at) begin
        m_fdu = ~gt[(inj_at - 1) % 8];
      end else begin
        m_fdu = gt[(pos / STEP) % 8];
        m_wrap = (pos % (8 * STEP)) == 0;
      end
    end
  endtask
  task automatic cyc(input bit en, input bit k, input bit inj);
    hb.enable = en; hb.kick = k; hb.inject = inj;
    @(posedge clk);
    mstep(en, k, inj);
    #1;
    chk("fdu", hb.fdu, m_fdu);
    chk("wrap", 3'(hb.wrap), 3'(m_wrap));
    chk("stalled", 3'(hb.stalled), 3'(m_stalled));
  endtask
  initial begin
    hb.enable = 1'b0; hb.kick = 1'b0; hb.inject = 1'b0;
    mreset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_fdu", hb.fdu, 3'b000);
    chk("rst_wrap", 3'(hb.wrap), 3'b000);
    chk("rst_stalled", 3'(hb.stalled), 3'b000);
    // full Gray cycle with periodic kicks
    cyc(1, 0, 0);
    for (int t = 0; t < 40; t++) begin
      cyc(1, t % 20 == 19, 0);
      chk("seq", hb.fdu, gt[((t + 1) / STEP) % 8]);
      if (t + 1 == 32) chk("wrap32", 3'(hb.wrap), 3'b001);
    end
    // kick timeout stall, freeze and resync
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    for (int t = 0; t < 75; t++) cyc(1, t == 10, 0);
    chk("stall_set", 3'(hb.stalled), 3'b001);
    chk("stall_code", hb.fdu, 3'b011);
    repeat (5) cyc(1, 0, 0);
    chk("frozen", hb.fdu, 3'b011);
    cyc(1, 1, 0);
    chk("resync_fdu", hb.fdu, 3'b000);
    chk("resync_stalled", 3'(hb.stalled), 3'b000);
    repeat (4) cyc(1, 0, 0);
    chk("resume", hb.fdu, 3'b001);
    // kick exactly on the timeout cycle
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    for (int t = 0; t < 63; t++) cyc(1, 0, 0);
    cyc(1, 1, 0);
    for (int t = 0; t < 40; t++) begin
      cyc(1, 0, 0);
      chk("no_stall", 3'(hb.stalled), 3'b000);
    end
    // fault injection at 011
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (9) cyc(1, 0, 0);
    chk("pre_inj", hb.fdu, 3'b011);
    cyc(1, 0, 1);
    repeat (2) cyc(1, 0, 0);
    chk("illegal", hb.fdu, 3'b100);
    repeat (4) cyc(1, 0, 0);
    chk("inj_zero", hb.fdu, 3'b000);
    chk("inj_nowrap", 3'(hb.wrap), 3'b000);
    repeat (4) cyc(1, 0, 0);
    chk("after_inj", hb.fdu, 3'b001);
    // async reset mid-sequence, then disable with a pending inject
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (17) cyc(1, 0, 0);
    chk("pre_rst", hb.fdu, 3'b110);
    #1 reset = 1'b1;
    #1 chk("async_rst", hb.fdu, 3'b000);
    mreset();
    #2 reset = 1'b0;
    cyc(1, 0, 0);
    repeat (20) cyc(1, 0, 0);
    chk("pre_off", hb.fdu, 3'b111);
    cyc(1, 0, 1);
    cyc(0, 0, 0);
    chk("en_off", hb.fdu, 3'b000);
    cyc(1, 0, 0);
    repeat (12) cyc(1, 0, 0);
    chk("pend_clr", hb.fdu, 3'b010);
    // randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) > 1, $urandom_range(0, 39) == 0, $urandom_range(0, 24) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
